muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clk.
REQ-002 The block SHALL expose these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request from control unit, sampled only in IDLE
- op  in  1  0 = signed MULT, 1 = signed DIV
- a  in  32  multiplicand / dividend (rs)
- b  in  32  multiplier / divisor (rt)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, result valid
- hilo_write  out  1  one-cycle pulse, coincident with done
- hi  out  32  MULT: product[63:32]; DIV: remainder
- lo  out  32  MULT: product[31:0]; DIV: quotient
- div_zero  out  1  one-cycle pulse, DIV with b == 0

Function
REQ-003 The block SHALL implement the states IDLE, MULT_RUN, DIV_RUN, FINISH and EXCP.
REQ-004 In IDLE, on start=1 the block SHALL latch a, b and op, then go to MULT_RUN (op=0), DIV_RUN (op=1, b!=0) or EXCP (op=1, b==0).
REQ-005 MULT_RUN and DIV_RUN SHALL each run exactly 32 iterations, counted by a 6-bit counter cleared on entry, then go to FINISH.
REQ-006 FINISH SHALL drive hi/lo with the final result and pulse done=1 and hilo_write=1 for one cycle, then return to IDLE.
REQ-007 Latency: if start is sampled at edge N, done and hilo_write SHALL be high exactly during the cycle after edge N+33.
REQ-008 EXCP SHALL pulse div_zero=1 for one cycle (the cycle after edge N+1), leave hi/lo unchanged, never assert done or hilo_write, and return to IDLE.
REQ-009 MULT SHALL produce the full signed 64-bit two's-complement product (shift-add on magnitudes, sign applied at FINISH).
REQ-010 DIV SHALL use restoring division on magnitudes; the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-011 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000, with no flag raised.
REQ-012 start SHALL be ignored while busy=1; operands SHALL come only from the latched copies, so a/b changes mid-run have no effect.
REQ-013 hi and lo SHALL change only in FINISH and SHALL otherwise hold the last result.
REQ-014 start asserted in the same cycle that FINISH or EXCP returns to IDLE SHALL be ignored; it is accepted only when sampled in IDLE.

Reset
REQ-015 Reset SHALL put the block in IDLE and clear busy, done, hilo_write, div_zero, hi, lo, the counter and all internal registers to 0.
REQ-016 Reset asserted mid-operation SHALL abort the run with no done, hilo_write or div_zero pulse; reset has priority over start.

Structure
REQ-017 The state encoding, op encoding (OP_MULT=0, OP_DIV=1) and ITER_COUNT=32 SHALL live in the shared CPU control package.
REQ-018 One combinational sub-module, muldiv_step, SHALL compute a single shift-add or shift-subtract iteration; the FSM, counter and sign handling SHALL stay in muldiv_sequencer.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- MULT a=7, b=-3 (0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done 33 cycles after start.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; hilo_write coincident with done.
- DIV a=5, b=0 -> div_zero pulse in the cycle after edge N+1; no done; hi/lo keep their previous values.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- Second start and operand changes at cycle 10 of a MULT -> ignored; the original result is returned and busy stays high until done.
- Reset at cycle 15 of a DIV -> IDLE next cycle, all outputs 0, no done pulse; a new MULT then completes normally.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared control definitions for the multiply/divide sequencer: the FSM
// state encoding, the op encoding seen on the op input, the iteration count
// of the shift-add / shift-subtract loop, and a small magnitude helper used
// when operands are latched.
// ---------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    FINISH   = 3'd3,
    EXCP     = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_COUNT = 32;

  // Counter value seen during the final iteration (counter starts at 0).
  localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31 when the result is read as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] value);
    return value[31] ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response bundle between the control unit and the sequencer.
//   start      request, sampled only while the sequencer is idle
//   op         0 = signed MULT, 1 = signed DIV
//   a, b       multiplicand/dividend (rs), multiplier/divisor (rt)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse, hi/lo hold a fresh result
//   hilo_write one-cycle pulse coincident with done
//   hi, lo     MULT: product[63:32]/[31:0]; DIV: remainder/quotient
//   div_zero   one-cycle pulse for DIV with b == 0
// master = control unit side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        hilo_write;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_write, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_write, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Purely combinational single iteration of the unsigned magnitude datapath.
//   op       OP_MULT: shift-add step, OP_DIV: restoring shift-subtract step
//   acc_in   MULT: running high half of the product; DIV: partial remainder
//   lo_in    MULT: multiplier bits still to consume / low product bits;
//            DIV: dividend bits still to shift in / quotient bits so far
//   m        MULT: multiplicand magnitude; DIV: divisor magnitude
//   acc_out, lo_out  register values after this iteration
// ---------------------------------------------------------------------------
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic        op,
  input  logic [31:0] acc_in,
  input  logic [31:0] lo_in,
  input  logic [31:0] m,
  output logic [31:0] acc_out,
  output logic [31:0] lo_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    sum     = {1'b0, acc_in} + (lo_in[0] ? {1'b0, m} : 33'd0);
    shifted = {acc_in, lo_in[31]};
    trial   = shifted - {1'b0, m};
    acc_out = acc_in;
    lo_out  = lo_in;

    if (op == OP_MULT) begin
      // The carry out of the add becomes the new top bit after the shift,
      // and the bit leaving acc drops into the top of lo.
      acc_out = sum[32:1];
      lo_out  = {sum[0], lo_in[31:1]};
    end else begin
      // shifted is at most 2*m - 1, so a borrow into bit 32 means the
      // divisor did not fit and the shifted value is restored.
      if (trial[32]) begin
        acc_out = shifted[31:0];
        lo_out  = {lo_in[30:0], 1'b0};
      end else begin
        acc_out = trial[31:0];
        lo_out  = {lo_in[30:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative signed 32x32 multiplier / 32/32 divider for the CPU HI/LO unit.
// Operands are converted to magnitudes when a request is accepted, the
// muldiv_step datapath runs ITER_COUNT iterations, and the signs are
// applied while in FINISH. A request is taken only in IDLE; a DIV with a
// zero divisor takes the EXCP path and raises div_zero instead of done.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (wins over start)
//   bus    muldiv_sequencer_if.slave request/response bundle
// Timing (start sampled at edge N):
//   done/hilo_write high during the cycle after edge N+33
//   div_zero high during the cycle after edge N+1
// ---------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  muldiv_sequencer_if.slave     bus
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        done_next;
  logic        div_zero_next;

  logic [5:0]  count;
  logic        op_r;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] acc;
  logic [31:0] work_lo;
  logic [31:0] m;

  logic [31:0] step_acc;
  logic [31:0] step_lo;

  logic        done_r;
  logic        div_zero_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [63:0] prod_mag;
  logic [63:0] prod_signed;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] hi_final;
  logic [31:0] lo_final;

  muldiv_step u_step (
    .op      (op_r),
    .acc_in  (acc),
    .lo_in   (work_lo),
    .m       (m),
    .acc_out (step_acc),
    .lo_out  (step_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is only looked at in IDLE, so requests arriving while busy or in
  // the cycle FINISH/EXCP hands back to IDLE are dropped.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    done_next     = 1'b0;
    div_zero_next = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.op == OP_MULT) begin
            state_next = MULT_RUN;
          end else if (bus.b == 32'd0) begin
            state_next = EXCP;
          end else begin
            state_next = DIV_RUN;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (count == LAST_ITER) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      EXCP: begin
        div_zero_next = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sign fix-up of the magnitude result. The quotient is negative when the
  // operand signs differ; the remainder follows the dividend. The
  // 0x80000000 / -1 case falls out naturally: magnitude quotient 2^31
  // negates back to 0x80000000.
  always_comb begin
    prod_mag    = {acc, work_lo};
    prod_signed = (neg_a ^ neg_b) ? (~prod_mag + 64'd1) : prod_mag;
    quo_signed  = (neg_a ^ neg_b) ? (~work_lo + 32'd1) : work_lo;
    rem_signed  = neg_a ? (~acc + 32'd1) : acc;
    if (op_r == OP_MULT) begin
      hi_final = prod_signed[63:32];
      lo_final = prod_signed[31:0];
    end else begin
      hi_final = rem_signed;
      lo_final = quo_signed;
    end
  end

  // Datapath and registered outputs. Operands enter only through the
  // accept branch, so later changes on a/b cannot disturb a running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 6'd0;
      op_r       <= 1'b0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      acc        <= 32'd0;
      work_lo    <= 32'd0;
      m          <= 32'd0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      done_r     <= done_next;
      div_zero_r <= div_zero_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r  <= bus.op;
            neg_a <= bus.a[31];
            neg_b <= bus.b[31];
            count <= 6'd0;
            acc   <= 32'd0;
            if (bus.op == OP_MULT) begin
              m       <= magnitude(bus.a);
              work_lo <= magnitude(bus.b);
            end else begin
              m       <= magnitude(bus.b);
              work_lo <= magnitude(bus.a);
            end
          end
        end
        MULT_RUN, DIV_RUN: begin
          acc     <= step_acc;
          work_lo <= step_lo;
          count   <= count + 6'd1;
        end
        FINISH: begin
          hi_r <= hi_final;
          lo_r <= lo_final;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_r;
  assign bus.hilo_write = done_r;
  assign bus.div_zero   = div_zero_r;
  assign bus.hi         = hi_r;
  assign bus.lo         = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Scoreboard bench for muldiv_sequencer. applyStimulus issues a request and
// pushes the expected response (computed with 64-bit signed arithmetic) into
// a queue; an independent negedge monitor pops an entry whenever the DUT
// pulses done/hilo_write/div_zero and compares result, flags and timing.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  typedef struct {
    bit          is_excp;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cycle = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  exp_t        sb[$];
  exp_t        mon_e;

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; k is the edge count when start is driven, so the
  // sampling edge is k+1.
  task automatic applyStimulus(input logic op_in, input logic [31:0] a_in, input logic [31:0] b_in, output int k);
    exp_t   e;
    longint sa;
    longint sbv;
    longint p;
    longint q;
    longint r;
    int     n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    checkOutput("idle_before_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    bus.op    = op_in;
    bus.a     = a_in;
    bus.b     = b_in;
    k   = cycle;
    sa  = longint'($signed(a_in));
    sbv = longint'($signed(b_in));
    if (op_in == OP_DIV && b_in == 32'd0) begin
      e.is_excp = 1'b1;
      e.hi      = last_hi;
      e.lo      = last_lo;
      e.due     = k + 2;
    end else begin
      e.is_excp = 1'b0;
      e.due     = k + 34;
      if (op_in == OP_MULT) begin
        p    = sa * sbv;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end else begin
        q    = sa / sbv;
        r    = sa % sbv;
        e.hi = r[31:0];
        e.lo = q[31:0];
      end
      last_hi = e.hi;
      last_lo = e.lo;
    end
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && (bus.done || bus.hilo_write || bus.div_zero)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 64'({bus.done, bus.hilo_write, bus.div_zero}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_cycle", 64'(cycle), 64'(mon_e.due));
        checkOutput("done", 64'(bus.done), mon_e.is_excp ? 64'd0 : 64'd1);
        checkOutput("hilo_write", 64'(bus.hilo_write), mon_e.is_excp ? 64'd0 : 64'd1);
        checkOutput("div_zero", 64'(bus.div_zero), mon_e.is_excp ? 64'd1 : 64'd0);
        checkOutput("hi", 64'(bus.hi), 64'(mon_e.hi));
        checkOutput("lo", 64'(bus.lo), 64'(mon_e.lo));
      end
    end
  end

  initial begin
    int          k;
    logic        rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) tick();

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hilo_write", 64'(bus.hilo_write), 64'd0);
    checkOutput("reset_div_zero", 64'(bus.div_zero), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    tick();
    checkOutput("reset_start_dropped", 64'(bus.busy), 64'd0);

    $display("[TB] directed: MULT 7 x -3");
    applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFD, k);
    waitIdle();
    checkOutput("mult_7_m3_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("mult_7_m3_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

    $display("[TB] directed: DIV -7 / 2");
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, k);
    waitIdle();
    checkOutput("div_m7_2_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("div_m7_2_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);

    $display("[TB] directed: DIV 5 / 0, start during EXCP ignored");
    applyStimulus(OP_DIV, 32'd5, 32'd0, k);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    checkOutput("excp_start_ignored", 64'(bus.busy), 64'd0);
    waitIdle();
    checkOutput("div0_hi_held", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("div0_lo_held", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);

    $display("[TB] directed: overflow corners");
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, k);
    waitIdle();
    checkOutput("div_min_m1_hi", 64'(bus.hi), 64'd0);
    checkOutput("div_min_m1_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
    applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, k);
    waitIdle();
    checkOutput("mult_min_min_hi", 64'(bus.hi), 64'h0000_0000_4000_0000);
    checkOutput("mult_min_min_lo", 64'(bus.lo), 64'd0);

    $display("[TB] directed: start and operand changes mid MULT");
    applyStimulus(OP_MULT, 32'h0001_2345, 32'hFFFF_0001, k);
    while (cycle <= k + 33) begin
      bus.a = $urandom;
      bus.b = (cycle == k + 10) ? 32'd0 : $urandom;
      bus.op = (cycle == k + 10) ? OP_DIV : bus.op;
      bus.start = (cycle == k + 10);
      checkOutput("busy_mid_run", 64'(bus.busy), 64'd1);
      tick();
    end
    bus.start = 1'b0;
    checkOutput("busy_after_done", 64'(bus.busy), 64'd0);
    waitIdle();
    checkOutput("mid_run_busy_final", 64'(bus.busy), 64'd0);

    $display("[TB] directed: start during FINISH ignored");
    applyStimulus(OP_MULT, 32'd123, 32'd456, k);
    while (cycle < k + 33) tick();
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    tick();
    bus.start = 1'b0;
    checkOutput("finish_start_ignored", 64'(bus.busy), 64'd0);
    tick();
    checkOutput("finish_start_ignored2", 64'(bus.busy), 64'd0);
    waitIdle();
    checkOutput("mult_123_456_lo", 64'(bus.lo), 64'd56088);

    $display("[TB] directed: reset mid DIV");
    applyStimulus(OP_DIV, 32'd1000, 32'd7, k);
    while (cycle < k + 15) tick();
    reset = 1'b1;
    sb.delete();
    last_hi = 32'd0;
    last_lo = 32'd0;
    tick();
    reset = 1'b0;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_div_zero", 64'(bus.div_zero), 64'd0);
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    repeat (30) tick();
    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd9, k);
    waitIdle();
    checkOutput("after_abort_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEE);

    $display("[TB] random phase");
    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000;
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, k);
      if ($urandom_range(0, 1) == 1) waitIdle();
    end
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
